// File: rtl/cam_capture.sv
// Camera DVP capture: synchronises OV-style pclk/vsync/href/data into the system
// clock domain, pairs bytes into RGB565 words and feeds the SDRAM write FIFO.
module cam_capture #(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_100M_i,
  input  logic        rst_i,
  input  logic        capture_en_i,
  input  logic        cam_pclk_i,
  input  logic        cam_vsync_i,
  input  logic        cam_href_i,
  input  logic [7:0]  cam_data_i,
  input  logic        fifo_full_i,
  output logic        wr_fifo_en_o,
  output logic [15:0] wr_fifo_data_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic [9:0]  line_cnt_o,
  output logic [10:0] pix_cnt_o,
  output logic        overflow_o,
  output logic        line_err_o
);

  // state    | meaning
  // IDLE     | capture disabled
  // ARM      | enabled, waiting for vsync high so we never start mid-frame
  // WAIT_SOF | in vertical blanking, waiting for vsync fall
  // CAPTURE  | active frame, pairing bytes into pixels
  typedef enum logic [1:0] {IDLE, ARM, WAIT_SOF, CAPTURE} state_t;

  localparam logic [10:0] H_LIM   = 11'(H_PIXELS);
  localparam logic [9:0]  V_LIM   = 10'(V_LINES);
  localparam logic [10:0] PIX_MAX = 11'h7FF;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] pclk_sync, vsync_sync, href_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   pclk_d, vsync_d, href_d;
  logic                   s_pclk, s_vsync, s_href;
  logic [7:0]             s_data;
  logic                   pclk_rise, vsync_rise, vsync_fall, href_fall;

  logic        capturing;
  logic        phase;
  logic        pend;
  logic [7:0]  hi_byte;
  logic        line_active, pix_room, take, line_end;
  logic [10:0] pix_cnt_post;

  // All camera signals share one sync depth so data stays aligned with its pclk edge.
  always_ff @(posedge clk_100M_i) begin
    if (rst_i) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 8'h00;
      pclk_d     <= 1'b0;
      vsync_d    <= 1'b0;
      href_d     <= 1'b0;
    end else begin
      pclk_sync    <= {pclk_sync[SYNC_STAGES-2:0], cam_pclk_i};
      vsync_sync   <= {vsync_sync[SYNC_STAGES-2:0], cam_vsync_i};
      href_sync    <= {href_sync[SYNC_STAGES-2:0], cam_href_i};
      data_sync[0] <= cam_data_i;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      pclk_d       <= s_pclk;
      vsync_d      <= s_vsync;
      href_d       <= s_href;
    end
  end

  assign s_pclk     = pclk_sync[SYNC_STAGES-1];
  assign s_vsync    = vsync_sync[SYNC_STAGES-1];
  assign s_href     = href_sync[SYNC_STAGES-1];
  assign s_data     = data_sync[SYNC_STAGES-1];
  assign pclk_rise  = s_pclk & ~pclk_d;
  assign vsync_rise = s_vsync & ~vsync_d;
  assign vsync_fall = ~s_vsync & vsync_d;
  assign href_fall  = ~s_href & href_d;

  always_ff @(posedge clk_100M_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (capture_en_i) state_nxt = ARM;
      ARM:      if (s_vsync) state_nxt = WAIT_SOF;
      WAIT_SOF: if (vsync_fall) state_nxt = CAPTURE;
      CAPTURE:  if (vsync_rise) state_nxt = capture_en_i ? WAIT_SOF : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_start_o = 1'b0;
    frame_done_o  = 1'b0;
    capturing     = 1'b0;
    case (state)
      WAIT_SOF: frame_start_o = vsync_fall;
      CAPTURE: begin
        capturing    = 1'b1;
        frame_done_o = vsync_rise;
      end
      default: ;
    endcase
  end

  // A pending pixel is resolved in the strobe cycle so fifo_full_i is judged live.
  assign line_active  = line_cnt_o < V_LIM;
  assign pix_room     = pix_cnt_o < H_LIM;
  assign take         = pend & capturing & line_active;
  assign wr_fifo_en_o = take & pix_room & ~fifo_full_i;
  assign line_end     = capturing & href_fall;
  assign pix_cnt_post = (take && pix_cnt_o != PIX_MAX) ? pix_cnt_o + 11'd1 : pix_cnt_o;

  always_ff @(posedge clk_100M_i) begin
    if (rst_i) begin
      line_cnt_o     <= 10'd0;
      pix_cnt_o      <= 11'd0;
      overflow_o     <= 1'b0;
      line_err_o     <= 1'b0;
      phase          <= 1'b0;
      pend           <= 1'b0;
      hi_byte        <= 8'h00;
      wr_fifo_data_o <= 16'h0000;
    end else if (frame_start_o) begin
      line_cnt_o <= 10'd0;
      pix_cnt_o  <= 11'd0;
      overflow_o <= 1'b0;
      line_err_o <= 1'b0;
      phase      <= 1'b0;
      pend       <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (capturing && pclk_rise && s_href) begin
        if (!phase) begin
          hi_byte <= s_data;
          phase   <= 1'b1;
        end else begin
          wr_fifo_data_o <= {hi_byte, s_data};
          phase          <= 1'b0;
          pend           <= 1'b1;
        end
      end
      if (take && !pix_room) line_err_o <= 1'b1;
      if (take && pix_room && fifo_full_i) overflow_o <= 1'b1;
      // Line end sees the count including any pixel resolved this same cycle.
      if (line_end) begin
        if (line_active && pix_cnt_post != H_LIM) line_err_o <= 1'b1;
        if (line_active) line_cnt_o <= line_cnt_o + 10'd1;
        pix_cnt_o <= 11'd0;
        phase     <= 1'b0;
      end else begin
        pix_cnt_o <= pix_cnt_post;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: drives directed frames with random pixel bytes and
// compares captured words, pulses, counters and flags against a frame-level model.
`timescale 1ns/1ps
module tb_cam_capture;

  localparam int H = 4;
  localparam int V = 4;

  logic        clk_100M = 1'b0;
  logic        rst = 1'b1;
  logic        cap_en = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        fifo_full = 1'b0;
  logic        wr_fifo_en;
  logic [15:0] wr_fifo_data;
  logic        frame_start, frame_done;
  logic [9:0]  line_cnt;
  logic [10:0] pix_cnt;
  logic        overflow, line_err;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic [15:0] act_q[$];
  logic [15:0] exp_q[$];

  cam_capture #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(2)) dut (
    .clk_100M_i     (clk_100M),
    .rst_i          (rst),
    .capture_en_i   (cap_en),
    .cam_pclk_i     (cam_pclk),
    .cam_vsync_i    (cam_vsync),
    .cam_href_i     (cam_href),
    .cam_data_i     (cam_data),
    .fifo_full_i    (fifo_full),
    .wr_fifo_en_o   (wr_fifo_en),
    .wr_fifo_data_o (wr_fifo_data),
    .frame_start_o  (frame_start),
    .frame_done_o   (frame_done),
    .line_cnt_o     (line_cnt),
    .pix_cnt_o      (pix_cnt),
    .overflow_o     (overflow),
    .line_err_o     (line_err)
  );

  always #5 clk_100M = ~clk_100M;

  always @(negedge clk_100M) begin
    if (wr_fifo_en) act_q.push_back(wr_fifo_data);
    if (frame_start) start_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One camera pixel clock period (~16.7 MHz); inputs change while pclk is low.
  task automatic pclk_cycle();
    #30 cam_pclk = 1'b1;
    #30 cam_pclk = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"}, {15'd0, wr_fifo_en, wr_fifo_data}, 32'd0);
    chk({tag, "_b"}, {8'd0, frame_start, frame_done, line_cnt, pix_cnt, overflow, line_err}, 32'd0);
  endtask

  task automatic run_frame(input int nlines, input int xl, input int full_idx,
                           input int en_off, input int en_on, input int rst_at,
                           input bit expect_cap);
    int gidx = 0;
    int s0, d0, npix, nchk;
    bit did_rst = 0;
    bit exp_ovf = 0;
    bit exp_lerr = 0;
    logic [7:0] hi, lo;
    exp_q.delete();
    act_q.delete();
    s0 = start_cnt;
    d0 = done_cnt;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    repeat (4) pclk_cycle();
    cam_vsync = 1'b0;
    repeat (4) pclk_cycle();
    chk("frame_start_pulses", start_cnt - s0, expect_cap ? 1 : 0);
    if (expect_cap) begin
      chk("start_line_cnt", line_cnt, 0);
      chk("start_overflow", overflow, 0);
      chk("start_line_err", line_err, 0);
    end
    for (int l = 0; l < nlines; l++) begin
      if (l == en_off) cap_en = 1'b0;
      if (l == en_on) cap_en = 1'b1;
      npix = H + ((l == xl) ? 1 : 0);
      for (int p = 0; p < npix; p++) begin
        if (gidx == rst_at) begin
          @(negedge clk_100M) rst = 1'b1;
          @(negedge clk_100M);
          check_all_zero("mid_reset");
          rst = 1'b0;
          #3;
          did_rst = 1;
        end
        hi = 8'($urandom);
        lo = 8'($urandom);
        fifo_full = (gidx == full_idx);
        cam_href = 1'b1;
        cam_data = hi;
        pclk_cycle();
        cam_data = lo;
        pclk_cycle();
        #30;
        fifo_full = 1'b0;
        if (expect_cap && !did_rst && l < V) begin
          if (p < H && gidx != full_idx) exp_q.push_back({hi, lo});
          if (p >= H) exp_lerr = 1;
          else if (gidx == full_idx) exp_ovf = 1;
          chk("pix_cnt_run", pix_cnt, p + 1);
          if (gidx == full_idx) chk("overflow_set", overflow, 1);
        end
        gidx++;
      end
      if (l == xl) begin
        cam_data = 8'($urandom);
        pclk_cycle();
      end
      if (l < V && npix != H) exp_lerr = 1;
      cam_href = 1'b0;
      repeat (3) pclk_cycle();
    end
    cam_vsync = 1'b1;
    repeat (3) pclk_cycle();
    chk("frame_done_pulses", done_cnt - d0, (expect_cap && rst_at < 0) ? 1 : 0);
    chk("strobe_count", act_q.size(), exp_q.size());
    nchk = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) chk("pixel_data", act_q[i], exp_q[i]);
    if (expect_cap) begin
      if (rst_at >= 0) begin
        check_all_zero("after_reset_frame");
      end else begin
        chk("end_line_cnt", line_cnt, (nlines < V) ? nlines : V);
        chk("end_overflow", overflow, exp_ovf);
        chk("end_line_err", line_err, exp_lerr);
        chk("end_pix_cnt", pix_cnt, 0);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_100M);
    check_all_zero("in_reset");
    rst = 1'b0;
    @(negedge clk_100M);
    check_all_zero("after_reset");
    #3;
    cap_en = 1'b1;
    run_frame(4, -1, -1, -1, -1, -1, 1);  // clean frame
    run_frame(4, -1,  4, -1, -1, -1, 1);  // fifo full on 5th pixel
    run_frame(4,  1, -1, -1, -1, -1, 1);  // long line + odd byte; overflow cleared
    run_frame(4, -1, -1,  1, -1, -1, 1);  // enable dropped in line 2
    run_frame(4, -1, -1, -1, -1, -1, 0);  // idle frame
    run_frame(4, -1, -1, -1,  1, -1, 0);  // enable raised mid-frame
    run_frame(4, -1, -1, -1, -1, -1, 1);  // following frame captured
    run_frame(4, -1, -1, -1, -1,  9, 1);  // reset mid-line 3
    run_frame(4, -1, -1, -1, -1, -1, 1);  // resumes after full vsync sequence
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
